// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word/mask types plus the arbiter state and port enums.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0] lc3b_mem_wmask;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} lc3b_arb_state;
  typedef enum logic {ARB_I, ARB_D} lc3b_arb_port;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (I) and data access (D).
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_read,
  input  lc3b_word      i_address,
  output logic          i_resp,
  output lc3b_word      i_rdata,
  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_mem_wmask d_byte_enable,
  input  lc3b_word      d_address,
  input  lc3b_word      d_wdata,
  output logic          d_resp,
  output lc3b_word      d_rdata,
  input  logic          mem_resp,
  input  lc3b_word      mem_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output lc3b_word      mem_address,
  output lc3b_word      mem_wdata,
  output lc3b_mem_wmask mem_byte_enable
);
  lc3b_arb_state state_q, state_d;
  lc3b_arb_port last_q, last_d;
  logic req_i, req_d, take_i, take_d;
  logic mem_read_d, mem_write_d;
  lc3b_word mem_address_d, mem_wdata_d;
  lc3b_mem_wmask mem_byte_enable_d;
  always_comb begin
    req_i = i_read;
    req_d = d_read | d_write;
    take_i = req_i & (~req_d | (FIXED_PRIO == 0 && last_q == ARB_D));
    take_d = req_d & ~take_i;
    state_d = state_q;
    last_d = last_q;
    mem_read_d = mem_read;
    mem_write_d = mem_write;
    mem_address_d = mem_address;
    mem_wdata_d = mem_wdata;
    mem_byte_enable_d = mem_byte_enable;
    if (state_q == IDLE) begin
      if (take_i) begin
        state_d = SERVE_I;
        last_d = ARB_I;
        mem_read_d = 1'b1;
        mem_write_d = 1'b0;
        mem_address_d = i_address;
        mem_byte_enable_d = 2'b11;
      end else if (take_d) begin
        // a simultaneous read+write request is treated as a write
        state_d = SERVE_D;
        last_d = ARB_D;
        mem_read_d = ~d_write;
        mem_write_d = d_write;
        mem_address_d = d_address;
        mem_wdata_d = d_write ? d_wdata : mem_wdata;
        mem_byte_enable_d = d_write ? d_byte_enable : 2'b11;
      end
    end else if (mem_resp) begin
      state_d = IDLE;
      mem_read_d = 1'b0;
      mem_write_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= ARB_D;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_address <= '0;
      mem_wdata <= '0;
      mem_byte_enable <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      mem_read <= mem_read_d;
      mem_write <= mem_write_d;
      mem_address <= mem_address_d;
      mem_wdata <= mem_wdata_d;
      mem_byte_enable <= mem_byte_enable_d;
    end
  end
  assign i_resp = (state_q == SERVE_I) & mem_resp;
  assign d_resp = (state_q == SERVE_D) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: round-robin (u0) and fixed-priority (u1) arbiters against a memory responder and ordering model.
module tb_mem_arbiter;
  import lc3b_types::*;
  logic clk = 0;
  logic rst;
  always #5 clk = ~clk;
  logic i_read, d_read, d_write;
  lc3b_word i_address, d_address, d_wdata;
  lc3b_mem_wmask d_be;
  logic mem_resp [2] = '{1'b0, 1'b0};
  lc3b_word mem_rdata [2] = '{16'h0, 16'h0};
  logic i_resp [2], d_resp [2], mem_read [2], mem_write [2];
  lc3b_word i_rdata [2], d_rdata [2], mem_address [2], mem_wdata [2];
  lc3b_mem_wmask mem_be [2];
  int n_cmp = 0, n_err = 0;
  int lat [2] = '{1, 1};
  int cnt [2] = '{0, 0};
  bit use_fixed = 0, noise = 0;
  lc3b_word fixed_rd = 16'h0;

  mem_arbiter #(.FIXED_PRIO(0)) u0 (
    .clk(clk), .rst(rst), .i_read(i_read), .i_address(i_address), .i_resp(i_resp[0]), .i_rdata(i_rdata[0]),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_be), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp[0]), .d_rdata(d_rdata[0]), .mem_resp(mem_resp[0]), .mem_rdata(mem_rdata[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]),
    .mem_byte_enable(mem_be[0]));
  mem_arbiter #(.FIXED_PRIO(1)) u1 (
    .clk(clk), .rst(rst), .i_read(i_read), .i_address(i_address), .i_resp(i_resp[1]), .i_rdata(i_rdata[1]),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_be), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp[1]), .d_rdata(d_rdata[1]), .mem_resp(mem_resp[1]), .mem_rdata(mem_rdata[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]),
    .mem_byte_enable(mem_be[1]));

  // memory model: answers lat cycles after a strobe appears; optional spurious resp while idle
  always begin
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst || !(mem_read[k] || mem_write[k]) || mem_resp[k]) begin
        mem_resp[k] = noise && !rst && !(mem_read[k] || mem_write[k]) && ($urandom_range(3) == 0);
        if (mem_resp[k]) mem_rdata[k] = 16'($urandom);
        cnt[k] = 0;
      end else begin
        cnt[k]++;
        if (cnt[k] >= lat[k]) begin
          mem_resp[k] = 1'b1;
          mem_rdata[k] = use_fixed ? fixed_rd : 16'($urandom);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #3;
  endtask

  task automatic clear_inputs;
    i_read = 0; d_read = 0; d_write = 0;
    i_address = 0; d_address = 0; d_wdata = 0; d_be = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    clear_inputs();
    noise = 0;
    use_fixed = 0;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1;
    clear_inputs();
    i_read = 1; d_write = 1; i_address = 16'h1111; d_address = 16'h2222; d_wdata = 16'h3333; d_be = 2'b01;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({mem_read[k], mem_write[k], mem_address[k], mem_wdata[k], mem_be[k], i_resp[k], d_resp[k]} !== '0) begin
        n_err++;
        $display("FAIL reset u%0d: rd=%b wr=%b addr=%h wd=%h be=%b iresp=%b dresp=%b want all zero",
                 k, mem_read[k], mem_write[k], mem_address[k], mem_wdata[k], mem_be[k], i_resp[k], d_resp[k]);
      end
    end
    rst = 0;
    clear_inputs();
    tick();
  endtask

  task automatic test_single_i;
    bit seen;
    int cyc;
    do_reset();
    lat = '{3, 3};
    use_fixed = 1;
    fixed_rd = 16'h1234;
    i_read = 1;
    i_address = 16'h0040;
    tick();
    n_cmp++;
    if (mem_read[0] !== 1 || mem_write[0] !== 0 || mem_address[0] !== 16'h0040 || mem_be[0] !== 2'b11) begin
      n_err++;
      $display("FAIL single_i strobe: rd=%b wr=%b addr=%h be=%b want 1 0 0040 11", mem_read[0], mem_write[0], mem_address[0], mem_be[0]);
    end
    seen = 0;
    cyc = 1;
    for (int t = 0; t < 20 && !seen; t++) begin
      n_cmp++;
      if (d_resp[0] !== 0) begin
        n_err++;
        $display("FAIL single_i d_resp: got %b want 0", d_resp[0]);
      end
      if (i_resp[0] === 1) begin
        seen = 1;
        n_cmp++;
        if (i_rdata[0] !== 16'h1234 || cyc != 3) begin
          n_err++;
          $display("FAIL single_i resp: rdata=%h cycle=%0d want 1234 cycle 3", i_rdata[0], cyc);
        end
        i_read = 0;
      end else begin
        tick();
        cyc++;
      end
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL single_i timeout: i_resp=0 want 1");
    end
    tick();
    n_cmp++;
    if (i_resp[0] !== 0 || mem_read[0] !== 0) begin
      n_err++;
      $display("FAIL single_i after: i_resp=%b rd=%b want 0 0", i_resp[0], mem_read[0]);
    end
  endtask

  task automatic test_d_write;
    bit seen;
    do_reset();
    lat = '{2, 2};
    d_write = 1; d_address = 16'h8002; d_wdata = 16'hBEEF; d_be = 2'b10;
    tick();
    n_cmp++;
    if (mem_write[0] !== 1 || mem_read[0] !== 0 || mem_address[0] !== 16'h8002 || mem_wdata[0] !== 16'hBEEF || mem_be[0] !== 2'b10) begin
      n_err++;
      $display("FAIL d_write strobe: wr=%b rd=%b addr=%h wd=%h be=%b want 1 0 8002 beef 10",
               mem_write[0], mem_read[0], mem_address[0], mem_wdata[0], mem_be[0]);
    end
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      n_cmp++;
      if (i_resp[0] !== 0) begin
        n_err++;
        $display("FAIL d_write i_resp: got %b want 0", i_resp[0]);
      end
      if (d_resp[0] === 1) begin
        seen = 1;
        d_write = 0;
      end else tick();
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL d_write timeout: d_resp=0 want 1");
    end
    tick();
    n_cmp++;
    if (mem_write[0] !== 0 || d_resp[0] !== 0) begin
      n_err++;
      $display("FAIL d_write after: wr=%b d_resp=%b want 0 0", mem_write[0], d_resp[0]);
    end
  endtask

  task automatic test_rr_tie;
    int g [2][$];
    bit prev [2];
    int last_resp [2];
    int nresp [2];
    do_reset();
    lat = '{2, 2};
    prev = '{0, 0};
    nresp = '{0, 0};
    last_resp = '{0, 0};
    i_read = 1; i_address = 16'h0100;
    d_read = 1; d_address = 16'h0200;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if ((mem_read[k] || mem_write[k]) && !prev[k]) begin
          g[k].push_back(mem_address[k] == 16'h0100 ? 0 : 1);
          if (nresp[k] > 0) begin
            n_cmp++;
            if (cyc - last_resp[k] != 2) begin
              n_err++;
              $display("FAIL tie gap u%0d: regrant %0d cycles after resp want 2", k, cyc - last_resp[k]);
            end
          end
        end
        if (i_resp[k] || d_resp[k]) begin
          last_resp[k] = cyc;
          nresp[k]++;
        end
        prev[k] = mem_read[k] || mem_write[k];
      end
    end
    n_cmp++;
    if (g[0].size() < 4 || g[1].size() < 4) begin
      n_err++;
      $display("FAIL tie count: grants u0=%0d u1=%0d want >=4", g[0].size(), g[1].size());
    end else begin
      for (int n = 0; n < 4; n++) begin
        n_cmp++;
        if (g[0][n] != n % 2) begin
          n_err++;
          $display("FAIL tie rr grant %0d: port=%0d want %0d", n, g[0][n], n % 2);
        end
        n_cmp++;
        if (g[1][n] != 1) begin
          n_err++;
          $display("FAIL tie fixed grant %0d: port=%0d want 1", n, g[1][n]);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_fixed_prio;
    int dn;
    bit got;
    do_reset();
    lat = '{2, 2};
    i_read = 1; i_address = 16'h0100;
    d_read = 1; d_address = 16'h0200;
    dn = 0;
    for (int t = 0; t < 60 && dn < 3; t++) begin
      tick();
      n_cmp++;
      if (i_resp[1] !== 0) begin
        n_err++;
        $display("FAIL fixed wait: i_resp=%b want 0 while D requests", i_resp[1]);
      end
      if (d_resp[1] === 1) dn++;
    end
    d_read = 0;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      tick();
      if (mem_read[1] || mem_write[1]) begin
        got = 1;
        n_cmp++;
        if (mem_address[1] !== 16'h0100 || mem_read[1] !== 1) begin
          n_err++;
          $display("FAIL fixed drop: addr=%h rd=%b want 0100 1", mem_address[1], mem_read[1]);
        end
      end
    end
    if (!got || dn < 3) begin
      n_cmp++; n_err++;
      $display("FAIL fixed timeout: d_resps=%0d regrant=%b want 3 1", dn, got);
    end
    clear_inputs();
  endtask

  task automatic test_mid_change;
    bit seen;
    do_reset();
    lat = '{4, 4};
    i_read = 1; i_address = 16'h0040;
    tick();
    i_address = 16'h0050;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      n_cmp++;
      if (mem_address[0] !== 16'h0040) begin
        n_err++;
        $display("FAIL mid_change: addr=%h want 0040", mem_address[0]);
      end
      if (i_resp[0] === 1) begin
        seen = 1;
        i_read = 0;
      end else tick();
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL mid_change timeout: i_resp=0 want 1");
    end
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    lat = '{10, 10};
    d_write = 1; d_address = 16'h8002; d_wdata = 16'hBEEF; d_be = 2'b10;
    tick();
    tick();
    n_cmp++;
    if (mem_write[0] !== 1) begin
      n_err++;
      $display("FAIL reset_mid pre: wr=%b want 1", mem_write[0]);
    end
    rst = 1;
    #1;
    n_cmp++;
    if ({mem_read[0], mem_write[0], mem_address[0], mem_wdata[0], mem_be[0], d_resp[0]} !== '0) begin
      n_err++;
      $display("FAIL reset_mid async: rd=%b wr=%b addr=%h wd=%h be=%b dresp=%b want all zero",
               mem_read[0], mem_write[0], mem_address[0], mem_wdata[0], mem_be[0], d_resp[0]);
    end
    clear_inputs();
    tick();
    rst = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      n_cmp++;
      if (d_resp[0] !== 0 || mem_write[0] !== 0 || mem_read[0] !== 0) begin
        n_err++;
        $display("FAIL reset_mid idle: dresp=%b wr=%b rd=%b want 0 0 0", d_resp[0], mem_write[0], mem_read[0]);
      end
    end
  endtask

  // reference: resp must match the held request; after each resp one idle cycle, and the
  // next winner is the other port if it is requesting in that idle cycle, else the same port
  task automatic test_random;
    int exp_next, port_last, served, r;
    bit idle_chk;
    do_reset();
    noise = 1;
    lat = '{$urandom_range(1, 4), 1};
    exp_next = -1; port_last = 0; served = 0; idle_chk = 0;
    for (int t = 0; t < 1500; t++) begin
      tick();
      n_cmp++;
      if (i_resp[0] && d_resp[0]) begin
        n_err++;
        $display("FAIL rand both_resp: i_resp=1 d_resp=1 want at most one");
      end
      if (idle_chk) begin
        n_cmp++;
        if (mem_read[0] || mem_write[0]) begin
          n_err++;
          $display("FAIL rand idle: rd=%b wr=%b want 0 0 after resp", mem_read[0], mem_write[0]);
        end
      end
      if (i_resp[0]) begin
        n_cmp++;
        if (mem_read[0] !== 1 || mem_write[0] !== 0 || mem_address[0] !== i_address || mem_be[0] !== 2'b11 || i_rdata[0] !== mem_rdata[0]) begin
          n_err++;
          $display("FAIL rand i_txn: rd=%b wr=%b addr=%h be=%b rdata=%h want 1 0 %h 11 %h",
                   mem_read[0], mem_write[0], mem_address[0], mem_be[0], i_rdata[0], i_address, mem_rdata[0]);
        end
        if (exp_next >= 0) begin
          n_cmp++;
          if (exp_next != 0) begin
            n_err++;
            $display("FAIL rand order: served I want D");
          end
        end
      end
      if (d_resp[0]) begin
        n_cmp++;
        if (mem_read[0] !== !d_write || mem_write[0] !== d_write || mem_address[0] !== d_address ||
            (d_write && (mem_wdata[0] !== d_wdata || mem_be[0] !== d_be)) || (!d_write && mem_be[0] !== 2'b11) ||
            d_rdata[0] !== mem_rdata[0]) begin
          n_err++;
          $display("FAIL rand d_txn: rd=%b wr=%b addr=%h wd=%h be=%b rdata=%h want wr=%b addr=%h wd=%h be=%b rdata=%h",
                   mem_read[0], mem_write[0], mem_address[0], mem_wdata[0], mem_be[0], d_rdata[0],
                   d_write, d_address, d_wdata, d_write ? d_be : 2'b11, mem_rdata[0]);
        end
        if (exp_next >= 0) begin
          n_cmp++;
          if (exp_next != 1) begin
            n_err++;
            $display("FAIL rand order: served D want I");
          end
        end
      end
      if (i_resp[0]) i_read = 0;
      else if (!i_read && $urandom_range(2) == 0) begin
        i_read = 1;
        i_address = 16'($urandom);
      end
      if (d_resp[0]) begin
        d_read = 0;
        d_write = 0;
      end else if (!(d_read || d_write) && $urandom_range(2) == 0) begin
        r = $urandom_range(2);
        d_read = (r != 1);
        d_write = (r != 0);
        d_address = 16'($urandom);
        d_wdata = 16'($urandom);
        d_be = 2'($urandom);
      end
      if (idle_chk) begin
        if (port_last == 0) exp_next = (d_read || d_write) ? 1 : (i_read ? 0 : -1);
        else exp_next = i_read ? 0 : ((d_read || d_write) ? 1 : -1);
        idle_chk = 0;
      end
      if (i_resp[0] || d_resp[0]) begin
        port_last = i_resp[0] ? 0 : 1;
        idle_chk = 1;
        exp_next = -1;
        lat[0] = $urandom_range(1, 4);
        served++;
      end
    end
    n_cmp++;
    if (served < 50) begin
      n_err++;
      $display("FAIL rand progress: served=%0d want >=50", served);
    end
    noise = 0;
    clear_inputs();
    tick();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_single_i();
    test_d_write();
    test_rr_tie();
    test_fixed_prio();
    test_mid_change();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
